// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bundle for shift_arbiter.
//   a_*    requester A: valid/ready handshake, 32-bit operand, 5-bit shamt, 2-bit op
//   b_*    requester B: same fields as A
//   resp_* result channel: valid/ready handshake, 32-bit data, requester id, error flag
// Modports: slave = arbiter side, master = requesters and consumer side.
interface shift_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic [4:0]  a_shamt;
    logic [1:0]  a_op;

    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
    logic [4:0]  b_shamt;
    logic [1:0]  b_op;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic        resp_err;

    modport slave (
        input  a_valid, a_data, a_shamt, a_op,
        output a_ready,
        input  b_valid, b_data, b_shamt, b_op,
        output b_ready,
        output resp_valid, resp_data, resp_id, resp_err,
        input  resp_ready
    );

    modport master (
        output a_valid, a_data, a_shamt, a_op,
        input  a_ready,
        output b_valid, b_data, b_shamt, b_op,
        input  b_ready,
        input  resp_valid, resp_data, resp_id, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit shifter under round-robin
// arbitration; each accepted request produces one registered, tagged result
// that is held until the consumer takes it.
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-high reset
//   bus       shift_arbiter_if.slave (A/B requests, result channel)
//   a_grants  A accept counter, saturating (only with SHIFT_ARB_STATS_EN)
//   b_grants  B accept counter, saturating (only with SHIFT_ARB_STATS_EN)
// Optional feature macro: SHIFT_ARB_STATS_EN enables the grant counters.

// Five-stage logarithmic left shifter, zero fill.
module shift_arbiter_lsh (
    input  logic [31:0] din,
    input  logic [4:0]  shamt,
    output logic [31:0] dout
);
    logic [5:0][31:0] stage;

    assign stage[0] = din;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        assign stage[k+1] = shamt[k] ? (stage[k] << (1 << k)) : stage[k];
    end

    assign dout = stage[5];
endmodule

module shift_arbiter #(
    parameter bit          RR_INIT = 1'b0,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    shift_arbiter_if.slave    bus
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] a_grants,
    output logic [STAT_W-1:0] b_grants
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    if (STAT_W == 0) begin : g_bad_stat_w
        $error("shift_arbiter: STAT_W must be at least 1");
    end

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [31:0] data_q, data_d;
    logic        id_q, id_d;
    logic        err_q, err_d;

    logic        can_issue;
    logic        grant_b;
    logic        a_ready_c, b_ready_c;
    logic        accept;

    logic [31:0] sel_data;
    logic [4:0]  sel_shamt;
    logic [1:0]  sel_op;
    logic [31:0] lsh_in, lsh_out;
    logic [31:0] fill_mask;
    logic [31:0] shift_res;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    // Operand select follows the grant; harmless when nothing is granted.
    assign sel_data  = grant_b ? bus.b_data  : bus.a_data;
    assign sel_shamt = grant_b ? bus.b_shamt : bus.a_shamt;
    assign sel_op    = grant_b ? bus.b_op    : bus.a_op;

    // Right shifts reuse the left shifter by reversing operand and result.
    assign lsh_in = (sel_op == OP_SLL) ? sel_data : rev32(sel_data);

    shift_arbiter_lsh u_lsh (
        .din   (lsh_in),
        .shamt (sel_shamt),
        .dout  (lsh_out)
    );

    // Top sel_shamt bits set: same as ~rev32(all-ones << shamt), built as a thermometer.
    always_comb begin
        fill_mask = '0;
        for (int j = 0; j < 32; j++) begin
            fill_mask[31-j] = (5'(j) < sel_shamt);
        end
    end

    // Final result by op; the reserved op yields zero.
    always_comb begin
        shift_res = '0;
        unique case (sel_op)
            OP_SLL:  shift_res = lsh_out;
            OP_SRL:  shift_res = rev32(lsh_out);
            OP_SRA:  shift_res = rev32(lsh_out) | (fill_mask & {32{sel_data[31]}});
            OP_RSV:  shift_res = '0;
            default: shift_res = '0;
        endcase
    end

    // Arbitration, handshake and next-state logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        id_d      = id_q;
        err_d     = err_q;
        a_ready_c = 1'b0;
        b_ready_c = 1'b0;

        can_issue = (state_q == IDLE) || bus.resp_ready;
        // B wins when it is the only requester or holds the priority pointer.
        grant_b   = bus.b_valid && (!bus.a_valid || ptr_q);

        if (can_issue) begin
            a_ready_c = bus.a_valid && !grant_b;
            b_ready_c = grant_b;
        end
        accept = a_ready_c || b_ready_c;

        unique case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (bus.resp_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            data_d = shift_res;
            id_d   = grant_b;
            err_d  = (sel_op == OP_RSV);
            ptr_d  = !grant_b;
        end
    end

    // State and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= RR_INIT;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign bus.a_ready    = a_ready_c;
    assign bus.b_ready    = b_ready_c;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = data_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_err   = err_q;

`ifdef SHIFT_ARB_STATS_EN
    // Saturating per-requester accept counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_grants <= '0;
            b_grants <= '0;
        end else begin
            if (a_ready_c && (a_grants != {STAT_W{1'b1}})) begin
                a_grants <= a_grants + STAT_W'(1);
            end
            if (b_ready_c && (b_grants != {STAT_W{1'b1}})) begin
                b_grants <= b_grants + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed plus randomized bench for shift_arbiter, checked
// against a transaction-level reference model (SV shift operators, pointer bit).
module tb_shift_arbiter;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    shift_arbiter_if bus ();

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] a_grants;
    logic [15:0] b_grants;
`endif

    shift_arbiter #(.RR_INIT(1'b0), .STAT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .a_grants (a_grants),
        .b_grants (b_grants)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state.
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_id;
    logic        m_err;
    logic        m_ptr;
    int          m_ga;
    int          m_gb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                              input logic [1:0] op);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return 32'($signed(d) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 32'h0;
        m_id    = 1'b0;
        m_err   = 1'b0;
        m_ptr   = 1'b0;
        m_ga    = 0;
        m_gb    = 0;
    endtask

    task automatic check_outputs();
        check("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
        check("resp_data",  64'(bus.resp_data),  64'(m_data));
        check("resp_id",    64'(bus.resp_id),    64'(m_id));
        check("resp_err",   64'(bus.resp_err),   64'(m_err));
`ifdef SHIFT_ARB_STATS_EN
        check("a_grants", 64'(a_grants), 64'(m_ga));
        check("b_grants", 64'(b_grants), 64'(m_gb));
`endif
    endtask

    // One clock: drive requests, check handshake, advance model, check result.
    task automatic do_cycle(input logic av, input logic [31:0] ad, input logic [4:0] ash,
                            input logic [1:0] aop, input logic bv, input logic [31:0] bd,
                            input logic [4:0] bsh, input logic [1:0] bop, input logic rr);
        logic can, exp_ar, exp_br;
        bus.a_valid = av; bus.a_data = ad; bus.a_shamt = ash; bus.a_op = aop;
        bus.b_valid = bv; bus.b_data = bd; bus.b_shamt = bsh; bus.b_op = bop;
        bus.resp_ready = rr;
        #1;
        can    = !m_valid || rr;
        exp_ar = can && av && (!bv || !m_ptr);
        exp_br = can && bv && (!av || m_ptr);
        check("a_ready", 64'(bus.a_ready), 64'(exp_ar));
        check("b_ready", 64'(bus.b_ready), 64'(exp_br));
        if (exp_ar) begin
            m_valid = 1'b1; m_data = ref_shift(ad, ash, aop); m_id = 1'b0;
            m_err = (aop == 2'b11); m_ptr = 1'b1;
            if (m_ga < 65535) m_ga++;
        end else if (exp_br) begin
            m_valid = 1'b1; m_data = ref_shift(bd, bsh, bop); m_id = 1'b1;
            m_err = (bop == 2'b11); m_ptr = 1'b0;
            if (m_gb < 65535) m_gb++;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic a_only(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                          input logic rr);
        do_cycle(1'b1, d, sh, op, 1'b0, 32'h0, 5'd0, 2'b00, rr);
    endtask

    task automatic b_only(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                          input logic rr);
        do_cycle(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, d, sh, op, rr);
    endtask

    task automatic idle_cycle(input logic rr);
        do_cycle(1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 32'h0, 5'd0, 2'b00, rr);
    endtask

    // Assert reset between edges and require the result to vanish immediately.
    task automatic mid_cycle_reset();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(bus.resp_valid), 64'(0));
        check("async_rst_data",  64'(bus.resp_data),  64'(0));
        model_reset();
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    logic [31:0] held;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.a_valid = 1'b0; bus.a_data = 32'h0; bus.a_shamt = 5'd0; bus.a_op = 2'b00;
        bus.b_valid = 1'b0; bus.b_data = 32'h0; bus.b_shamt = 5'd0; bus.b_op = 2'b00;
        bus.resp_ready = 1'b0;
        model_reset();
        #12;
        check_outputs();
        reset = 1'b0;
        @(posedge clock);
        #1;

        // A only, SLL by 31.
        a_only(32'h0000_0001, 5'd31, 2'b00, 1'b1);
        check("sll31_data", 64'(bus.resp_data), 64'(32'h8000_0000));
        check("sll31_id",   64'(bus.resp_id),   64'(0));

        // B arithmetic and logical right shift.
        b_only(32'h8000_00F0, 5'd4, 2'b10, 1'b1);
        check("sra_data", 64'(bus.resp_data), 64'(32'hF800_000F));
        check("sra_id",   64'(bus.resp_id),   64'(1));
        b_only(32'h8000_00F0, 5'd4, 2'b01, 1'b1);
        check("srl_data", 64'(bus.resp_data), 64'(32'h0800_000F));

        // Both valid every cycle: grants alternate.
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)),
                     1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)), 1'b1);
            check("rr_alt_id", 64'(bus.resp_id), 64'(i % 2));
        end

        // Backpressure: result held, A stalled, then accepted on release.
        a_only(32'h1234_5678, 5'd3, 2'b00, 1'b1);
        held = bus.resp_data;
        for (int i = 0; i < 3; i++) begin
            a_only(32'hFFFF_0000, 5'd8, 2'b01, 1'b0);
            check("bp_hold", 64'(bus.resp_data), 64'(held));
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.a_ready), 64'(1));
        a_only(32'hFFFF_0000, 5'd8, 2'b01, 1'b1);
        check("bp_release_data", 64'(bus.resp_data), 64'(32'h00FF_FF00));

        // Reserved op and zero shift amounts.
        a_only(32'hDEAD_BEEF, 5'd7, 2'b11, 1'b1);
        check("rsv_data", 64'(bus.resp_data), 64'(0));
        check("rsv_err",  64'(bus.resp_err),  64'(1));
        for (int op = 0; op < 3; op++) begin
            a_only(32'hDEAD_BEEF, 5'd0, 2'(op), 1'b1);
            check("sh0_data", 64'(bus.resp_data), 64'(32'hDEAD_BEEF));
        end
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Randomized traffic with random backpressure and dropped requests.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                     2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                     2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 3) != 0));
        end

        // Reset while a result is held.
        a_only(32'h0000_00FF, 5'd4, 2'b00, 1'b0);
        if (!m_valid) a_only(32'h0000_00FF, 5'd4, 2'b00, 1'b1);
        check("pre_rst_valid", 64'(bus.resp_valid), 64'(1));
        mid_cycle_reset();

`ifdef SHIFT_ARB_STATS_EN
        for (int i = 0; i < 5; i++) begin
            a_only($urandom, 5'($urandom_range(0, 31)), 2'b00, 1'b1);
        end
        check("a_grants_5", 64'(a_grants), 64'(5));
        mid_cycle_reset();
        check("a_grants_0", 64'(a_grants), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit left-shift datapath between two requesters (A, B) with round-robin arbitration.
- Issues one shift per accepted request and registers the result with a requester tag.
- Holds the result until the consumer accepts it.
- Sits between the ALU-op decode (requester A), the address/immediate unit (requester B) and the shared result bus.

Parameters:
- RR_INIT, 0: requester given priority first after reset (0 = A, 1 = B).
- STAT_W, 16: width of each grant counter (used only with SHIFT_ARB_STATS_EN).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A's request is accepted this cycle.
- a_data  in  32  A operand.
- a_shamt  in  5  A shift amount.
- a_op  in  2  A operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- b_valid, b_ready, b_data, b_shamt, b_op  same as A, for requester B.
- resp_valid  out  1  registered result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  shift result.
- resp_id  out  1  requester that issued the result (0 = A, 1 = B).
- resp_err  out  1  request used reserved op 11.
- a_grants, b_grants  out  STAT_W  grant counters (only with SHIFT_ARB_STATS_EN).

Behaviour:
- Reset (async, high):
  - state = IDLE; resp_valid = 0; resp_data = 0; resp_id = 0; resp_err = 0.
  - Priority pointer = RR_INIT; counters = 0.
- FSM has two states.
  - IDLE: no result held.
  - RESP: result held, resp_valid = 1.
- can_issue = (state == IDLE) || resp_ready.
- Arbitration (combinational):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester named by the priority pointer.
  - a_ready = can_issue && grant == A; b_ready = can_issue && grant == B.
  - Never both ready in the same cycle.
- Accept (x_valid && x_ready):
  - On the next edge, latch resp_data = shift(x_data, x_shamt, x_op), resp_id = x, resp_err = (x_op == 11), resp_valid = 1, state = RESP.
  - Priority pointer moves to the other requester; it moves only on an accept.
- Latency: request accepted in cycle N gives resp_valid in cycle N+1.
- Throughput: back-to-back issue allowed. In RESP with resp_ready = 1 and a granted valid, the old result retires and the new one loads on the same edge, giving 1 result per cycle.
- RESP with resp_ready = 1 and no valid requester: state becomes IDLE, resp_valid = 0. resp_data, resp_id and resp_err hold their last values.
- RESP with resp_ready = 0: all resp_* outputs hold stable, and both x_ready = 0.
- Shift semantics (5-bit shamt, 0..31):
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with data[31].
  - shamt = 0 passes data unchanged for SLL, SRL and SRA.
  - Op 11: resp_data = 0, resp_err = 1, still consumes a grant and a turn.
- Datapath: exactly one instance of the team's 32-bit logarithmic left shifter.
  - Right shifts: bit-reverse the operand in, bit-reverse the result out.
  - SRA: OR in a fill mask, which is the reversed left shift of all-ones, inverted and gated by data[31].
- Requesters may drop valid without an accept; no state change results.
- Reset mid-RESP: result is discarded immediately and resp_valid drops asynchronously.

Optional Feature:
- SHIFT_ARB_STATS_EN defined:
  - a_grants and b_grants increment by 1 on each accept by A or B.
  - Counters saturate at 2^STAT_W-1 and are cleared by reset.
- Not defined: ports a_grants and b_grants are absent and no counter logic is built.

Test Plan:
- Reset then A only: a_data=0x0000_0001, a_shamt=31, a_op=00 -> a_ready=1 that cycle; next cycle resp_valid=1, resp_data=0x8000_0000, resp_id=0, resp_err=0.
- B SRA: b_data=0x8000_00F0, b_shamt=4, b_op=10 -> resp_data=0xF800_000F, resp_id=1. Same with op 01 -> 0x0800_000F.
- Both valid every cycle, resp_ready=1, RR_INIT=0:
  - Grants alternate A,B,A,B.
  - resp_id sequence 0,1,0,1 with resp_valid continuously 1.
- Backpressure: resp_ready=0 for 3 cycles with A valid -> a_ready=0 throughout; resp_data stable. Raising resp_ready -> A accepted that cycle.
- Edge ops:
  - a_op=11 -> resp_data=0, resp_err=1.
  - shamt=0 on 0xDEAD_BEEF for SLL, SRL and SRA -> 0xDEAD_BEEF each.
- Reset asserted while resp_valid=1 -> resp_valid=0 without waiting for a clock edge. With SHIFT_ARB_STATS_EN, 5 A grants then reset -> a_grants goes 5 then 0.
